// File: rtl/addsub_result_checker.sv
// addsub_result_checker
// Streaming self-check monitor for a signed add/subtract datapath. Each accepted
// {a, b, option, sum} vector is held in one pipeline stage. On the following edge
// the checker recomputes the expected result and updates the pass, fail and
// overflow statistics. It also captures the first failing vector. With
// STOP_ON_FAIL set, the first failure parks the checker in HALT until clear or rst.

module addsub_result_checker #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_option,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             error,
  output logic             halted,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_option,
  output logic [WIDTH-1:0] ff_sum,
  output logic [WIDTH-1:0] ff_expected
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Saturating increment: a counter at all-ones holds its value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Expected result, truncated to WIDTH bits (mod 2^WIDTH).
  function automatic logic [WIDTH-1:0] calc_expected(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic             opt);
    logic [WIDTH-1:0] r;
    if (opt) begin
      r = a - b;
    end else begin
      r = a + b;
    end
    return r;
  endfunction

  // Signed overflow of the exact result, detected from operand and result signs.
  function automatic logic is_overflow(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             opt,
                                       input logic [WIDTH-1:0] e);
    logic r;
    if (opt) begin
      r = (a[WIDTH-1] != b[WIDTH-1]) && (e[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r = (a[WIDTH-1] == b[WIDTH-1]) && (e[WIDTH-1] != a[WIDTH-1]);
    end
    return r;
  endfunction

  state_t           state_q, state_d;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_opt_q, s1_opt_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;

  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic             ff_opt_q, ff_opt_d;
  logic [WIDTH-1:0] ff_sum_q, ff_sum_d;
  logic [WIDTH-1:0] ff_exp_q, ff_exp_d;

  logic [WIDTH-1:0] exp_s;
  logic             ovf_s;
  logic             cmp_s;
  logic             pass_s;
  logic             fail_s;
  logic             halt_entry_s;
  logic             accept_s;
  logic             in_ready_s;
  logic             halted_s;

  // Compare stage: recompute the stage-1 vector and classify it; clear suppresses the compare.
  always_comb begin
    exp_s        = calc_expected(s1_a_q, s1_b_q, s1_opt_q);
    ovf_s        = is_overflow(s1_a_q, s1_b_q, s1_opt_q, exp_s);
    cmp_s        = s1_valid_q & ~clear;
    pass_s       = cmp_s & (exp_s == s1_sum_q);
    fail_s       = cmp_s & (exp_s != s1_sum_q);
    halt_entry_s = fail_s & STOP_ON_FAIL;
    accept_s     = in_valid & in_ready_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a failing compare halts when STOP_ON_FAIL is set; only clear resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (clear) begin
          state_d = ST_RUN;
        end else if (halt_entry_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (clear) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM outputs: accept only in RUN, and never on a clear edge.
  always_comb begin
    in_ready_s = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready_s = ~clear;
        halted_s   = 1'b0;
      end
      ST_HALT: begin
        in_ready_s = 1'b0;
        halted_s   = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
        halted_s   = 1'b0;
      end
    endcase
  end

  // Datapath next state: stage-1 load, statistics and first-failure capture.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_opt_d   = s1_opt_q;
    s1_sum_d   = s1_sum_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ovf_d      = ovf_q;
    error_d    = error_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_opt_d   = ff_opt_q;
    ff_sum_d   = ff_sum_q;
    ff_exp_d   = ff_exp_q;
    if (clear) begin
      s1_valid_d = 1'b0;
      pass_d     = {CNT_W{1'b0}};
      fail_d     = {CNT_W{1'b0}};
      ovf_d      = {CNT_W{1'b0}};
      error_d    = 1'b0;
      ff_a_d     = {WIDTH{1'b0}};
      ff_b_d     = {WIDTH{1'b0}};
      ff_opt_d   = 1'b0;
      ff_sum_d   = {WIDTH{1'b0}};
      ff_exp_d   = {WIDTH{1'b0}};
    end else begin
      // A vector accepted on the edge that enters HALT is dropped.
      s1_valid_d = accept_s & ~halt_entry_s;
      if (accept_s) begin
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_opt_d = in_option;
        s1_sum_d = in_sum;
      end else begin
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_opt_d = s1_opt_q;
        s1_sum_d = s1_sum_q;
      end
      if (pass_s) begin
        pass_d = sat_inc(pass_q);
      end else begin
        pass_d = pass_q;
      end
      if (cmp_s && ovf_s) begin
        ovf_d = sat_inc(ovf_q);
      end else begin
        ovf_d = ovf_q;
      end
      if (fail_s) begin
        fail_d  = sat_inc(fail_q);
        error_d = 1'b1;
        if (!error_q) begin
          ff_a_d   = s1_a_q;
          ff_b_d   = s1_b_q;
          ff_opt_d = s1_opt_q;
          ff_sum_d = s1_sum_q;
          ff_exp_d = exp_s;
        end else begin
          ff_a_d   = ff_a_q;
          ff_b_d   = ff_b_q;
          ff_opt_d = ff_opt_q;
          ff_sum_d = ff_sum_q;
          ff_exp_d = ff_exp_q;
        end
      end else begin
        fail_d  = fail_q;
        error_d = error_q;
      end
    end
  end

  // Datapath registers; rst discards any in-flight vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= {WIDTH{1'b0}};
      s1_b_q     <= {WIDTH{1'b0}};
      s1_opt_q   <= 1'b0;
      s1_sum_q   <= {WIDTH{1'b0}};
      pass_q     <= {CNT_W{1'b0}};
      fail_q     <= {CNT_W{1'b0}};
      ovf_q      <= {CNT_W{1'b0}};
      error_q    <= 1'b0;
      ff_a_q     <= {WIDTH{1'b0}};
      ff_b_q     <= {WIDTH{1'b0}};
      ff_opt_q   <= 1'b0;
      ff_sum_q   <= {WIDTH{1'b0}};
      ff_exp_q   <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_opt_q   <= s1_opt_d;
      s1_sum_q   <= s1_sum_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ovf_q      <= ovf_d;
      error_q    <= error_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_opt_q   <= ff_opt_d;
      ff_sum_q   <= ff_sum_d;
      ff_exp_q   <= ff_exp_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign halted      = halted_s;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign ovf_cnt     = ovf_q;
  assign error       = error_q;
  assign ff_a        = ff_a_q;
  assign ff_b        = ff_b_q;
  assign ff_option   = ff_opt_q;
  assign ff_sum      = ff_sum_q;
  assign ff_expected = ff_exp_q;

endmodule
